// File: rtl/cam_dma_burst_ctrl_if.sv
// Camera / FIFO / DMA signal bundle for cam_dma_burst_ctrl.
// The controller connects through the slave modport; the environment
// (camera source, FIFO, DMA engine) connects through the master modport.
interface cam_dma_burst_ctrl_if #(
  parameter int DATA_WIDTH = 48,
  parameter int FIFO_DEPTH = 1024
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  // control
  logic                  enable_i;
  logic                  ovf_clr_i;
  // camera side
  logic                  cam_valid_i;
  logic [DATA_WIDTH-1:0] cam_data_i;
  logic                  frame_end_i;
  // FIFO side
  logic                  fifo_wr_en_o;
  logic [DATA_WIDTH-1:0] fifo_wdata_o;
  logic                  fifo_full_i;
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_rdata_i;
  logic                  fifo_rd_en_o;
  // DMA stream side
  logic                  dma_tvalid_o;
  logic [DATA_WIDTH-1:0] dma_tdata_o;
  logic                  dma_tlast_o;
  logic                  dma_tready_i;
  // status
  logic [LEVEL_W-1:0]    level_o;
  logic                  busy_o;
  logic                  overflow_o;

  modport slave (
    input  enable_i, ovf_clr_i, cam_valid_i, cam_data_i, frame_end_i,
           fifo_full_i, fifo_empty_i, fifo_rdata_i, dma_tready_i,
    output fifo_wr_en_o, fifo_wdata_o, fifo_rd_en_o, dma_tvalid_o,
           dma_tdata_o, dma_tlast_o, level_o, busy_o, overflow_o
  );

  modport master (
    output enable_i, ovf_clr_i, cam_valid_i, cam_data_i, frame_end_i,
           fifo_full_i, fifo_empty_i, fifo_rdata_i, dma_tready_i,
    input  fifo_wr_en_o, fifo_wdata_o, fifo_rd_en_o, dma_tvalid_o,
           dma_tdata_o, dma_tlast_o, level_o, busy_o, overflow_o
  );
endinterface

// File: rtl/cam_dma_burst_ctrl.sv
// Camera-to-DMA burst controller.
// Pushes camera pixels into an external FWFT FIFO, tracks its occupancy,
// and drains it as DMA stream bursts: full BURST_LEN bursts whenever enough
// data is buffered, plus a short flush burst after a frame end.
module cam_dma_burst_ctrl #(
  parameter int DATA_WIDTH = 48,
  parameter int FIFO_DEPTH = 1024,
  parameter int BURST_LEN  = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  cam_dma_burst_ctrl_if.slave bus
);
  localparam int                 LEVEL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEVEL_W-1:0] BURST_LEN_L = LEVEL_W'(BURST_LEN);
  localparam logic [LEVEL_W-1:0] DEPTH_L     = LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] ONE_L       = LEVEL_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEVEL_W-1:0] beats_q, beats_d;
  logic               flush_pending_q, flush_pending_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;

  logic cam_take;
  logic wr_en;
  logic cam_drop;
  logic frame_mark;
  logic tvalid;
  logic rd_en;
  logic tlast;

  // Per-cycle decode of the camera write path and the DMA handshake.
  always_comb begin
    cam_take   = bus.cam_valid_i & bus.enable_i;
    wr_en      = cam_take & ~bus.fifo_full_i;
    cam_drop   = cam_take & bus.fifo_full_i;
    frame_mark = cam_take & bus.frame_end_i;
    tvalid     = (state_q == BURST) & ~bus.fifo_empty_i;
    rd_en      = tvalid & bus.dma_tready_i;
    tlast      = tvalid & (beat_cnt_q == (beats_q - ONE_L));
  end

  assign bus.fifo_wr_en_o = wr_en;
  assign bus.fifo_wdata_o = bus.cam_data_i;
  assign bus.fifo_rd_en_o = rd_en;
  assign bus.dma_tvalid_o = tvalid;
  assign bus.dma_tdata_o  = bus.fifo_rdata_i;
  assign bus.dma_tlast_o  = tlast;
  assign bus.level_o      = level_q;
  assign bus.busy_o       = busy_q;
  assign bus.overflow_o   = overflow_q;

  // Next-state logic: occupancy, sticky overflow, flush bookkeeping and burst FSM.
  always_comb begin
    state_d         = state_q;
    level_d         = level_q;
    beat_cnt_d      = beat_cnt_q;
    beats_d         = beats_q;
    flush_pending_d = flush_pending_q;
    overflow_d      = overflow_q;

    // A drop in the same cycle as a clear wins, so the new loss is not hidden.
    if (bus.ovf_clr_i) overflow_d = 1'b0;
    if (cam_drop)      overflow_d = 1'b1;

    if (wr_en && !rd_en && (level_q != DEPTH_L)) begin
      level_d = level_q + ONE_L;
    end else if (rd_en && !wr_en && (level_q != '0)) begin
      level_d = level_q - ONE_L;
    end

    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        if (bus.enable_i && (level_q >= BURST_LEN_L)) begin
          state_d = BURST;
          beats_d = BURST_LEN_L;
          // A full burst that empties the buffer also completes a pending flush.
          if (level_q == BURST_LEN_L) flush_pending_d = 1'b0;
        end else if (flush_pending_q) begin
          if (level_q == '0) begin
            flush_pending_d = 1'b0;
          end else if (bus.enable_i) begin
            state_d         = BURST;
            beats_d         = level_q;
            flush_pending_d = 1'b0;
          end
        end
      end
      BURST: begin
        if (rd_en) begin
          if (tlast) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + ONE_L;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame end (even a dropped one) always re-arms the flush.
    if (frame_mark) flush_pending_d = 1'b1;

    busy_d = (state_d == BURST);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q         <= IDLE;
      level_q         <= '0;
      beat_cnt_q      <= '0;
      beats_q         <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      level_q         <= level_d;
      beat_cnt_q      <= beat_cnt_d;
      beats_q         <= beats_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
      busy_q          <= busy_d;
    end
  end
endmodule

// File: tb/tb_cam_dma_burst_ctrl.sv
// Directed self-checking bench for cam_dma_burst_ctrl with a behavioural
// FWFT FIFO model and a stream monitor that records handshakes.
module tb_cam_dma_burst_ctrl;
  localparam int DW    = 48;
  localparam int DEPTH = 1024;
  localparam int BL    = 16;

  logic clk;
  logic rstn;

  int checks = 0;
  int errors = 0;
  int pixId  = 0;

  cam_dma_burst_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  cam_dma_burst_ctrl #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .BURST_LEN (BL)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FWFT FIFO, reset together with the controller.
  logic [DW-1:0] fifoMem [0:DEPTH-1];
  logic [9:0]    wrPtr;
  logic [9:0]    rdPtr;
  logic [10:0]   fifoCnt;
  logic          doWr;
  logic          doRd;

  assign doWr             = bus.fifo_wr_en_o && (fifoCnt != 11'(DEPTH));
  assign doRd             = bus.fifo_rd_en_o && (fifoCnt != 11'd0);
  assign bus.fifo_full_i  = (fifoCnt == 11'(DEPTH));
  assign bus.fifo_empty_i = (fifoCnt == 11'd0);
  assign bus.fifo_rdata_i = fifoMem[rdPtr];

  always @(posedge clk) begin
    if (!rstn) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (doWr) begin
        fifoMem[wrPtr] <= bus.fifo_wdata_o;
        wrPtr          <= wrPtr + 10'd1;
      end
      if (doRd) rdPtr <= rdPtr + 10'd1;
      fifoCnt <= fifoCnt + 11'(doWr) - 11'(doRd);
    end
  end

  // Stream monitor: counts handshakes, records tlast positions, checks ordering.
  int hsCount;
  int tlastCount;
  int tlastIdx [4];
  int orderErr;
  int expData;

  always @(negedge clk) begin
    if (!rstn) begin
      hsCount    <= 0;
      tlastCount <= 0;
      orderErr   <= 0;
      expData    <= 0;
      for (int i = 0; i < 4; i++) tlastIdx[i] <= -1;
    end else if (bus.dma_tvalid_o && bus.dma_tready_i) begin
      if (bus.dma_tdata_o != DW'(expData)) orderErr <= orderErr + 1;
      expData <= expData + 1;
      if (bus.dma_tlast_o) begin
        if (tlastCount < 4) tlastIdx[tlastCount] <= hsCount;
        tlastCount <= tlastCount + 1;
      end
      hsCount <= hsCount + 1;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic stepCycle(input bit toggleReady);
    if (toggleReady) bus.dma_tready_i = ~bus.dma_tready_i;
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input bit toggleReady);
    for (int i = 0; i < n; i++) stepCycle(toggleReady);
  endtask

  task automatic doReset();
    rstn               = 1'b0;
    bus.cam_valid_i    = 1'b0;
    bus.frame_end_i    = 1'b0;
    bus.ovf_clr_i      = 1'b0;
    bus.enable_i       = 1'b1;
    bus.dma_tready_i   = 1'b0;
    pixId              = 0;
    runCycles(2, 1'b0);
    rstn = 1'b1;
    runCycles(1, 1'b0);
  endtask

  task automatic applyStimulus(input int n, input bit feLast, input bit toggleReady);
    for (int i = 0; i < n; i++) begin
      bus.cam_valid_i = 1'b1;
      bus.cam_data_i  = DW'(pixId);
      bus.frame_end_i = feLast && (i == n - 1);
      stepCycle(toggleReady);
      pixId++;
    end
    bus.cam_valid_i = 1'b0;
    bus.frame_end_i = 1'b0;
  endtask

  task automatic waitHs(input string tag, input int target, input int budget);
    int k = 0;
    while ((hsCount < target) && (k < budget)) begin
      stepCycle(1'b0);
      k++;
    end
    checkOutput(tag, hsCount, target);
  endtask

  initial begin
    rstn             = 1'b0;
    bus.enable_i     = 1'b0;
    bus.ovf_clr_i    = 1'b0;
    bus.cam_valid_i  = 1'b0;
    bus.cam_data_i   = '0;
    bus.frame_end_i  = 1'b0;
    bus.dma_tready_i = 1'b0;

    // Reset state
    doReset();
    checkOutput("rst_busy",     bus.busy_o,       0);
    checkOutput("rst_level",    bus.level_o,      0);
    checkOutput("rst_overflow", bus.overflow_o,   0);
    checkOutput("rst_tvalid",   bus.dma_tvalid_o, 0);
    checkOutput("rst_tlast",    bus.dma_tlast_o,  0);
    checkOutput("rst_rd_en",    bus.fifo_rd_en_o, 0);

    // 40 pixels, no frame end: two full bursts, 8 left behind
    $display("[TB] test: two full bursts");
    doReset();
    bus.dma_tready_i = 1'b1;
    applyStimulus(40, 1'b0, 1'b0);
    waitHs("t1_hs_wait", 32, 200);
    runCycles(10, 1'b0);
    checkOutput("t1_hs",     hsCount,     32);
    checkOutput("t1_tlasts", tlastCount,  2);
    checkOutput("t1_tlast0", tlastIdx[0], 15);
    checkOutput("t1_tlast1", tlastIdx[1], 31);
    checkOutput("t1_level",  bus.level_o, 8);
    checkOutput("t1_busy",   bus.busy_o,  0);
    checkOutput("t1_order",  orderErr,    0);

    // 21 pixels with frame end: full burst plus 5-beat flush
    $display("[TB] test: frame-end flush");
    doReset();
    bus.dma_tready_i = 1'b1;
    applyStimulus(21, 1'b1, 1'b0);
    waitHs("t2_hs_wait", 21, 200);
    runCycles(10, 1'b0);
    checkOutput("t2_hs",     hsCount,     21);
    checkOutput("t2_tlasts", tlastCount,  2);
    checkOutput("t2_tlast0", tlastIdx[0], 15);
    checkOutput("t2_tlast1", tlastIdx[1], 20);
    checkOutput("t2_level",  bus.level_o, 0);
    checkOutput("t2_order",  orderErr,    0);
    // flush must be cleared: a lone pixel does not launch a burst
    applyStimulus(1, 1'b0, 1'b0);
    runCycles(10, 1'b0);
    checkOutput("t2_noflush_hs",    hsCount,     21);
    checkOutput("t2_noflush_level", bus.level_o, 1);
    checkOutput("t2_noflush_busy",  bus.busy_o,  0);

    // 1030 pixels with the DMA stalled: fill, overflow, clear
    $display("[TB] test: overflow");
    doReset();
    applyStimulus(1030, 1'b0, 1'b0);
    checkOutput("t3_level",    bus.level_o,    1024);
    checkOutput("t3_overflow", bus.overflow_o, 1);
    checkOutput("t3_hs",       hsCount,        0);
    checkOutput("t3_busy",     bus.busy_o,     1);
    bus.ovf_clr_i = 1'b1;
    stepCycle(1'b0);
    bus.ovf_clr_i = 1'b0;
    checkOutput("t3_ovf_clr", bus.overflow_o, 0);
    // drop and clear in the same cycle keeps the flag set
    bus.cam_valid_i = 1'b1;
    bus.cam_data_i  = DW'(pixId);
    bus.ovf_clr_i   = 1'b1;
    #1;
    checkOutput("t3_wr_blocked_full", bus.fifo_wr_en_o, 0);
    stepCycle(1'b0);
    bus.cam_valid_i = 1'b0;
    bus.ovf_clr_i   = 1'b0;
    checkOutput("t3_ovf_set_clr", bus.overflow_o, 1);

    // reset at beat 7 of a running burst
    $display("[TB] test: reset mid-burst");
    bus.dma_tready_i = 1'b1;
    waitHs("t6_hs_wait", 7, 50);
    checkOutput("t6_pre_busy",     bus.busy_o,     1);
    checkOutput("t6_pre_overflow", bus.overflow_o, 1);
    rstn = 1'b0;
    stepCycle(1'b0);
    checkOutput("t6_busy",     bus.busy_o,       0);
    checkOutput("t6_level",    bus.level_o,      0);
    checkOutput("t6_overflow", bus.overflow_o,   0);
    checkOutput("t6_tvalid",   bus.dma_tvalid_o, 0);
    rstn = 1'b1;

    // tready toggling every cycle during a 16-beat burst
    $display("[TB] test: tready toggling");
    doReset();
    applyStimulus(16, 1'b0, 1'b1);
    runCycles(60, 1'b1);
    checkOutput("t4_hs",     hsCount,     16);
    checkOutput("t4_tlasts", tlastCount,  1);
    checkOutput("t4_tlast0", tlastIdx[0], 15);
    checkOutput("t4_order",  orderErr,    0);
    checkOutput("t4_level",  bus.level_o, 0);

    // enable dropped after beat 3: burst completes, nothing new launches
    $display("[TB] test: enable drop mid-burst");
    doReset();
    applyStimulus(40, 1'b0, 1'b0);
    checkOutput("t5_busy_launch", bus.busy_o, 1);
    bus.dma_tready_i = 1'b1;
    waitHs("t5_hs_wait", 3, 50);
    bus.enable_i    = 1'b0;
    bus.cam_valid_i = 1'b1;
    bus.cam_data_i  = DW'(pixId);
    #1;
    checkOutput("t5_wr_blocked", bus.fifo_wr_en_o, 0);
    runCycles(40, 1'b0);
    bus.cam_valid_i = 1'b0;
    checkOutput("t5_hs",     hsCount,     16);
    checkOutput("t5_tlasts", tlastCount,  1);
    checkOutput("t5_tlast0", tlastIdx[0], 15);
    checkOutput("t5_busy",   bus.busy_o,  0);
    checkOutput("t5_level",  bus.level_o, 24);
    checkOutput("t5_order",  orderErr,    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
